// File: rtl/instr_exec_pkg.sv
// Shared decode constants and the 7-segment helper for the instruction execution unit.
// Field positions describe the 16-bit Instruction word driven by the front-panel control FSM.
package instr_exec_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int A_HI   = 11;
  localparam int A_LO   = 8;
  localparam int RSV_HI = 7;
  localparam int RSV_LO = 5;
  localparam int D_HI   = 4;
  localparam int D_LO   = 1;
  localparam int WE_BIT = 0;

  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUBI = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_CPY  = 4'd6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/instr_exec_seg7_scan.sv
// Four-digit multiplexed 7-segment scanner: dwell counter, digit mux and hex decoder.
// Only instantiated when SEVEN_SEG_EN is defined.
module seg7_scan
  import instr_exec_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  output logic [6:0] seg_out,
  output logic [3:0] an_out
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end
    // Outputs are registered from the next digit so segments and anode switch together.
    case (sel_d)
      2'd0: begin an_d = 4'b1110; seg_d = hex_to_seg(digit0); end
      2'd1: begin an_d = 4'b1101; seg_d = hex_to_seg(digit1); end
      2'd2: begin an_d = 4'b1011; seg_d = hex_to_seg(digit2); end
      default: begin an_d = 4'b0111; seg_d = SEG_BLANK; end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      sel_q <= 2'd0;
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign an_out  = an_q;

endmodule

// File: rtl/instr_exec_unit.sv
// Executes each new 16-bit Instruction word on a 16-entry register file and reports the result.
// Optional 7-segment display output is enabled with SEVEN_SEG_EN.
module instr_exec_unit
  import instr_exec_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 16
`ifdef SEVEN_SEG_EN
  ,
  parameter int SCAN_DIV = 50000
`endif
) (
  input  logic              CLK_In,
  input  logic              RST_In,
  input  logic [15:0]       Instruction,
  output logic [DATA_W-1:0] Read_Data,
  output logic [3:0]        Read_Addr,
  output logic              Carry,
  output logic              Exec_Pulse,
  output logic              Err
`ifdef SEVEN_SEG_EN
  ,
  output logic [6:0]        Seg_Out,
  output logic [3:0]        An_Out
`endif
);

  logic [15:0]       instr_q, instr_d;
  logic              prime_q, prime_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [3:0]        read_addr_q, read_addr_d;
  logic              carry_q, carry_d;
  logic              pulse_q, pulse_d;
  logic              err_q, err_d;

  logic [3:0]        opc, a_addr, d_addr;
  logic [2:0]        rsv;
  logic              we;
  logic              exec_new;
  logic [DATA_W-1:0] val_a, val_d, imm_a;
  logic [DATA_W:0]   sum_w, diff_w;
  logic              wr_en;
  logic [DATA_W-1:0] wr_val;

  assign opc    = Instruction[OPC_HI:OPC_LO];
  assign a_addr = Instruction[A_HI:A_LO];
  assign rsv    = Instruction[RSV_HI:RSV_LO];
  assign d_addr = Instruction[D_HI:D_LO];
  assign we     = Instruction[WE_BIT];

  // Control holds the word as a level: only a value change (or the first cycle after reset) executes.
  assign exec_new = prime_q | (Instruction != instr_q);

  assign val_a  = regs_q[a_addr];
  assign val_d  = regs_q[d_addr];
  assign imm_a  = DATA_W'(a_addr);
  assign sum_w  = {1'b0, val_d} + {1'b0, imm_a};
  assign diff_w = {1'b0, val_d} - {1'b0, imm_a};

  always_comb begin
    instr_d     = Instruction;
    prime_d     = 1'b0;
    regs_d      = regs_q;
    read_data_d = read_data_q;
    read_addr_d = read_addr_q;
    carry_d     = carry_q;
    err_d       = err_q;
    pulse_d     = exec_new;
    wr_en       = 1'b0;
    wr_val      = '0;
    if (exec_new) begin
      if (rsv != 3'd0) begin
        err_d = 1'b1;
      end else begin
        case (opc)
          OP_MOV: begin
            if (we) begin
              wr_en  = 1'b1;
              wr_val = imm_a;
            end else begin
              read_data_d = val_a;
              read_addr_d = a_addr;
            end
          end
          OP_ADDI: begin
            wr_en   = 1'b1;
            wr_val  = sum_w[DATA_W-1:0];
            carry_d = sum_w[DATA_W];
          end
          OP_SUBI: begin
            wr_en   = 1'b1;
            wr_val  = diff_w[DATA_W-1:0];
            carry_d = diff_w[DATA_W];
          end
          OP_AND: begin wr_en = 1'b1; wr_val = val_d & val_a; end
          OP_OR:  begin wr_en = 1'b1; wr_val = val_d | val_a; end
          OP_XOR: begin wr_en = 1'b1; wr_val = val_d ^ val_a; end
          OP_CPY: begin wr_en = 1'b1; wr_val = val_a; end
          default: err_d = 1'b1;
        endcase
      end
      // Every register write is mirrored onto the read-back outputs.
      if (wr_en) begin
        regs_d[d_addr] = wr_val;
        read_data_d    = wr_val;
        read_addr_d    = d_addr;
      end
    end
  end

  always_ff @(posedge CLK_In) begin
    if (RST_In) begin
      instr_q     <= '0;
      prime_q     <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      read_data_q <= '0;
      read_addr_q <= '0;
      carry_q     <= 1'b0;
      pulse_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      prime_q     <= prime_d;
      regs_q      <= regs_d;
      read_data_q <= read_data_d;
      read_addr_q <= read_addr_d;
      carry_q     <= carry_d;
      pulse_q     <= pulse_d;
      err_q       <= err_d;
    end
  end

  // Exec_Pulse is a single-cycle strobe; Read_Data/Read_Addr/Carry/Err are valid in that same cycle and held afterwards.
  assign Read_Data  = read_data_q;
  assign Read_Addr  = read_addr_q;
  assign Carry      = carry_q;
  assign Exec_Pulse = pulse_q;
  assign Err        = err_q;

`ifdef SEVEN_SEG_EN
  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg7_scan (
    .clk_in  (CLK_In),
    .rst_in  (RST_In),
    .digit0  (read_data_q[3:0]),
    .digit1  (read_addr_q),
    .digit2  ({3'b000, carry_q}),
    .seg_out (Seg_Out),
    .an_out  (An_Out)
  );
`endif

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit: reference model feeds an expected-result queue,
// a negedge monitor pops one entry per Exec_Pulse. Define SEVEN_SEG_EN to also exercise the scanner.
module tb_instr_exec_unit;

  logic        CLK_In = 1'b0;
  logic        RST_In = 1'b1;
  logic [15:0] Instruction = 16'h0000;
  logic [3:0]  Read_Data;
  logic [3:0]  Read_Addr;
  logic        Carry;
  logic        Exec_Pulse;
  logic        Err;
`ifdef SEVEN_SEG_EN
  logic [6:0]  Seg_Out;
  logic [3:0]  An_Out;
`endif

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Expected entry: {Read_Addr, Read_Data, Carry, Err}
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_exp, mon_obs;

  logic [3:0]  m_regs [16];
  logic [3:0]  m_rd, m_ra;
  logic        m_carry, m_err, m_prime;
  logic [15:0] m_last;

  instr_exec_unit #(
    .DATA_W   (4),
    .NUM_REGS (16)
`ifdef SEVEN_SEG_EN
    ,
    .SCAN_DIV (4)
`endif
  ) dut (
    .CLK_In      (CLK_In),
    .RST_In      (RST_In),
    .Instruction (Instruction),
    .Read_Data   (Read_Data),
    .Read_Addr   (Read_Addr),
    .Carry       (Carry),
    .Exec_Pulse  (Exec_Pulse),
    .Err         (Err)
`ifdef SEVEN_SEG_EN
    ,
    .Seg_Out     (Seg_Out),
    .An_Out      (An_Out)
`endif
  );

  // ---------------- clock ----------------
  always #5 CLK_In = ~CLK_In;

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK_In) begin
    if (Exec_Pulse === 1'b1) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pulse: got Exec_Pulse=1, required no pulse (queue empty)");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_obs = {Read_Addr, Read_Data, Carry, Err};
        if (mon_obs !== mon_exp) begin
          errors++;
          $display("FAIL sb_result: got {addr,data,c,e}=%h required %h at %0t", mon_obs, mon_exp, $time);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_exec(input logic [15:0] w);
    logic [3:0] opc, a, d;
    logic [4:0] s;
    logic [3:0] r;
    logic       wr;
    opc = w[15:12];
    a   = w[11:8];
    d   = w[4:1];
    wr  = 1'b0;
    r   = 4'h0;
    if (w[7:5] != 3'b000) begin
      m_err = 1'b1;
    end else begin
      case (opc)
        4'd0: begin
          if (w[0]) begin wr = 1'b1; r = a; end
          else begin m_rd = m_regs[a]; m_ra = a; end
        end
        4'd1: begin s = m_regs[d] + a; wr = 1'b1; r = s[3:0]; m_carry = s[4]; end
        4'd2: begin m_carry = (m_regs[d] < a); wr = 1'b1; r = m_regs[d] - a; end
        4'd3: begin wr = 1'b1; r = m_regs[d] & m_regs[a]; end
        4'd4: begin wr = 1'b1; r = m_regs[d] | m_regs[a]; end
        4'd5: begin wr = 1'b1; r = m_regs[d] ^ m_regs[a]; end
        4'd6: begin wr = 1'b1; r = m_regs[a]; end
        default: m_err = 1'b1;
      endcase
    end
    if (wr) begin
      m_regs[d] = r;
      m_rd = r;
      m_ra = d;
    end
    exp_q.push_back({m_ra, m_rd, m_carry, m_err});
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [15:0] w, input int hold);
    @(negedge CLK_In);
    Instruction = w;
    if (m_prime || (w != m_last)) model_exec(w);
    m_prime = 1'b0;
    m_last  = w;
    repeat (hold) @(negedge CLK_In);
  endtask

  task automatic do_reset(input logic [15:0] w_during, input logic [15:0] w_after);
    @(negedge CLK_In);
    RST_In = 1'b1;
    Instruction = w_during;
    for (int i = 0; i < 16; i++) m_regs[i] = 4'h0;
    m_rd = 4'h0; m_ra = 4'h0; m_carry = 1'b0; m_err = 1'b0;
    @(negedge CLK_In);
    checks++;
    if ({Exec_Pulse, Read_Data, Read_Addr, Carry, Err} !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs: got pulse,data,addr,c,e=%h required 000", {Exec_Pulse, Read_Data, Read_Addr, Carry, Err});
    end
`ifdef SEVEN_SEG_EN
    checks++;
    if ({Seg_Out, An_Out} !== 11'h7FF) begin
      errors++;
      $display("FAIL reset_seg: got seg=%h an=%h required seg=7f an=f", Seg_Out, An_Out);
    end
`endif
    Instruction = w_after;
    @(negedge CLK_In);
    RST_In = 1'b0;
    model_exec(w_after);
    m_prime = 1'b0;
    m_last  = w_after;
    repeat (2) @(negedge CLK_In);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int p0;
    p0 = pulse_cnt;
    do_reset(16'h0000, 16'h0000);
    repeat (10) @(negedge CLK_In);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL reset_single_pulse: got %0d pulses required 1", pulse_cnt - p0);
    end
    checks++;
    if (Read_Data !== 4'h0) begin
      errors++;
      $display("FAIL reset_read_data: got %h required 0", Read_Data);
    end
  endtask

  task automatic test_mov_read();
    int p0;
    p0 = pulse_cnt;
    drive(16'h0507, 3);
    drive(16'h0300, 3);
    checks++;
    if ({Read_Data, Read_Addr} !== 8'h53) begin
      errors++;
      $display("FAIL mov_read: got data=%h addr=%h required data=5 addr=3", Read_Data, Read_Addr);
    end
    checks++;
    if (pulse_cnt - p0 !== 2) begin
      errors++;
      $display("FAIL mov_read_pulses: got %0d required 2", pulse_cnt - p0);
    end
  endtask

  task automatic test_addi_hold();
    int p0;
    drive(16'h0F07, 2);
    p0 = pulse_cnt;
    drive(16'h1107, 20);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL addi_single_pulse: got %0d required 1", pulse_cnt - p0);
    end
    checks++;
    if ({Read_Data, Carry} !== 5'b0000_1) begin
      errors++;
      $display("FAIL addi_wrap: got data=%h carry=%b required data=0 carry=1", Read_Data, Carry);
    end
    drive(16'h0300, 2);
    checks++;
    if (Read_Data !== 4'h0) begin
      errors++;
      $display("FAIL addi_no_readd: got r3=%h required 0", Read_Data);
    end
    drive(16'h2107, 3);
    checks++;
    if ({Read_Data, Carry} !== 5'b1111_1) begin
      errors++;
      $display("FAIL subi_borrow: got data=%h carry=%b required data=f carry=1", Read_Data, Carry);
    end
  endtask

  task automatic test_logic_ops();
    logic [15:0] words [6];
    words = '{16'h0A09, 16'h3407, 16'h5409, 16'h4307, 16'h630B, 16'h0500};
    for (int i = 0; i < 6; i++) drive(words[i], 2);
    checks++;
    if ({Read_Data, Read_Addr, Carry} !== 9'b1010_0101_1) begin
      errors++;
      $display("FAIL logic_ops: got data=%h addr=%h carry=%b required data=a addr=5 carry=1", Read_Data, Read_Addr, Carry);
    end
    drive(16'h0400, 2);
    checks++;
    if (Read_Data !== 4'h0) begin
      errors++;
      $display("FAIL xor_self: got r4=%h required 0", Read_Data);
    end
  endtask

  task automatic test_reserved();
    int p0;
    drive(16'h0300, 2);
    p0 = pulse_cnt;
    drive(16'h00E7, 3);
    checks++;
    if ({Err, Read_Data, Read_Addr} !== 9'b1_1010_0011) begin
      errors++;
      $display("FAIL reserved_nop: got err=%b data=%h addr=%h required err=1 data=a addr=3", Err, Read_Data, Read_Addr);
    end
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL reserved_pulse: got %0d required 1", pulse_cnt - p0);
    end
    drive(16'h0300, 2);
    drive(16'h7123, 2);
    drive(16'h0507, 2);
    checks++;
    if ({Err, Read_Data} !== 5'b1_0101) begin
      errors++;
      $display("FAIL err_sticky: got err=%b data=%h required err=1 data=5", Err, Read_Data);
    end
  endtask

  task automatic test_reset_during_change();
    drive(16'h0F07, 2);
    do_reset(16'h0507, 16'h0300);
    checks++;
    if ({Read_Data, Read_Addr, Err} !== 9'b0000_0011_0) begin
      errors++;
      $display("FAIL reset_clears_regs: got data=%h addr=%h err=%b required data=0 addr=3 err=0", Read_Data, Read_Addr, Err);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        w = m_last;
      end else begin
        w[15:12] = 4'($urandom_range(0, 6));
        if ($urandom_range(0, 15) == 0) w[15:12] = 4'($urandom_range(7, 15));
        w[11:8] = 4'($urandom_range(0, 15));
        w[7:5]  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        w[4:1]  = 4'($urandom_range(0, 15));
        w[0]    = 1'($urandom_range(0, 1));
      end
      drive(w, $urandom_range(1, 3));
    end
  endtask

`ifdef SEVEN_SEG_EN
  task automatic test_seg();
    int n;
    do_reset(16'h0000, 16'h0000);
    drive(16'h0507, 1);
    n = 0;
    while (!(An_Out === 4'b1110 && Seg_Out === 7'h12) && n < 20) begin
      @(negedge CLK_In);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL seg_digit0: got an=%b seg=%h required an=1110 seg=12", An_Out, Seg_Out);
    end
    n = 0;
    while (An_Out !== 4'b1101 && n < 12) begin
      @(negedge CLK_In);
      n++;
    end
    checks++;
    if (Seg_Out !== 7'h30) begin
      errors++;
      $display("FAIL seg_digit1: got an=%b seg=%h required an=1101 seg=30", An_Out, Seg_Out);
    end
    n = 0;
    while (An_Out === 4'b1101 && n < 10) begin
      @(negedge CLK_In);
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL seg_dwell: got %0d cycles required 4", n);
    end
    checks++;
    if ({An_Out, Seg_Out} !== {4'b1011, 7'h40}) begin
      errors++;
      $display("FAIL seg_digit2: got an=%b seg=%h required an=1011 seg=40", An_Out, Seg_Out);
    end
    repeat (4) @(negedge CLK_In);
    checks++;
    if ({An_Out, Seg_Out} !== {4'b0111, 7'h7F}) begin
      errors++;
      $display("FAIL seg_digit3: got an=%b seg=%h required an=0111 seg=7f", An_Out, Seg_Out);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    m_prime = 1'b1;
    m_last  = 16'h0000;
    test_reset();
    test_mov_read();
    test_addi_hold();
    test_logic_ops();
    test_reserved();
    test_reset_during_change();
    test_random();
`ifdef SEVEN_SEG_EN
    test_seg();
`endif
    repeat (3) @(negedge CLK_In);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding results required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
